// File: rtl/mlp_result_reader.sv
// mlp_result_reader: starts the MLP, waits for done, reads each picture's scores and emits argmax per picture.
// Define RESULT_READER_SCORE_EN to add res_score_o carrying the winning score.
module mlp_result_reader #(
  parameter int MAX_NUMBER_PIC = 10,
  parameter int NUM_CLASS      = 10,
  parameter int DATA_W         = 16,
  parameter int Y_BASE         = 0,
  parameter int TIMEOUT_W      = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run_i,
  output logic                     busy_o,
  output logic                     start_o,
  input  logic                     done_intr_i,
  output logic                     y_en_o,
  output logic [9:0]               y_addr_o,
  input  logic signed [DATA_W-1:0] y_data_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [3:0]               res_class_o,
  output logic [3:0]               res_pic_o,
  output logic                     err_timeout_o,
  output logic                     all_done_o
`ifdef RESULT_READER_SCORE_EN
  ,
  output logic signed [DATA_W-1:0] res_score_o
`endif
);
  typedef enum logic [2:0] {IDLE, START, WAIT, READ, EMIT, FIN, TOUT} state_t;
  state_t state_q, state_d;
  logic [3:0] pic_q, pic_d, k_q, k_d, rd_k_q, cls_q, cls_d;
  logic [9:0] addr_q, addr_d;
  logic rd_vld_q, done_prev_q, valid_q, valid_d, err_q, err_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic edge_seen, last_k, take;

  function automatic logic [9:0] pic_addr(input logic [3:0] p);
    return 10'(Y_BASE + int'(p) * NUM_CLASS);
  endfunction

  assign edge_seen = done_intr_i && !done_prev_q;
  assign last_k    = k_q == 4'(NUM_CLASS - 1);
  assign wd_inc    = wd_q + 1'b1;
  // Data returned for index k is compared the cycle after its read; k=0 seeds the running max.
  assign take      = rd_vld_q && (rd_k_q == 4'd0 || y_data_i > max_q);

  always_comb begin
    state_d = state_q;
    pic_d   = pic_q;
    k_d     = k_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    err_d   = err_q;
    wd_d    = wd_q;
    max_d   = take ? y_data_i : max_q;
    cls_d   = take ? rd_k_q : cls_q;
    unique case (state_q)
      IDLE:  if (run_i) begin
        state_d = START;
        err_d   = 1'b0;
      end
      START: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT:  if (edge_seen) begin
        state_d = READ;
        pic_d   = 4'd0;
        k_d     = 4'd0;
        addr_d  = pic_addr(4'd0);
      end else if (&wd_inc) begin
        state_d = TOUT;
        err_d   = 1'b1;
      end else wd_d = wd_inc;
      READ:  begin
        k_d     = last_k ? 4'd0 : k_q + 4'd1;
        addr_d  = addr_q + 10'd1;
        state_d = last_k ? EMIT : READ;
      end
      EMIT:  if (!valid_q) valid_d = 1'b1;
      else if (res_ready_i) begin
        valid_d = 1'b0;
        if (pic_q == 4'(MAX_NUMBER_PIC - 1)) state_d = FIN;
        else begin
          state_d = READ;
          pic_d   = pic_q + 4'd1;
          addr_d  = pic_addr(pic_q + 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pic_q       <= '0;
      k_q         <= '0;
      rd_k_q      <= '0;
      cls_q       <= '0;
      addr_q      <= '0;
      rd_vld_q    <= 1'b0;
      done_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      wd_q        <= '0;
      max_q       <= '0;
    end else begin
      state_q     <= state_d;
      pic_q       <= pic_d;
      k_q         <= k_d;
      rd_k_q      <= k_q;
      cls_q       <= cls_d;
      addr_q      <= addr_d;
      rd_vld_q    <= state_q == READ;
      done_prev_q <= done_intr_i;
      valid_q     <= valid_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
      max_q       <= max_d;
    end
  end

  assign busy_o        = state_q != IDLE;
  assign start_o       = state_q == START;
  assign y_en_o        = state_q == READ;
  assign y_addr_o      = y_en_o ? addr_q : 10'd0;
  assign res_valid_o   = valid_q;
  assign res_class_o   = cls_q;
  assign res_pic_o     = pic_q;
  assign err_timeout_o = err_q;
  assign all_done_o    = state_q == FIN;
`ifdef RESULT_READER_SCORE_EN
  assign res_score_o   = max_q;
`endif
endmodule

// File: tb/tb_mlp_result_reader.sv
// tb_mlp_result_reader: directed bench with address/result scoreboards for mlp_result_reader.
module tb_mlp_result_reader;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, done = 1'b0, ready = 1'b0, run_t = 1'b0;
  logic busy, start, y_en, valid, err, all_done;
  logic busy_t, start_t, y_en_t, valid_t, err_t, all_done_t;
  logic [9:0] y_addr, y_addr_t;
  logic [3:0] cls, pic, cls_t, pic_t;
  logic signed [15:0] y_data = '0;
  logic signed [15:0] mem [0:1023];
`ifdef RESULT_READER_SCORE_EN
  logic signed [15:0] score, score_t;
`endif
  int n_chk = 0, n_err = 0, n_res = 0;
  int aq[$];
  logic [7:0] rq[$];
  logic [7:0] e_res;
  int v0[10] = '{3, -1, 7, 7, 0, 0, 0, 0, 0, 0};
  int v1[10] = '{-5, -2, -9, -9, -9, -9, -9, -9, -9, -9};

  mlp_result_reader dut (
    .clk(clk), .rst_n(rst_n), .run_i(run), .busy_o(busy), .start_o(start),
    .done_intr_i(done), .y_en_o(y_en), .y_addr_o(y_addr), .y_data_i(y_data),
    .res_valid_o(valid), .res_ready_i(ready), .res_class_o(cls), .res_pic_o(pic),
    .err_timeout_o(err), .all_done_o(all_done)
`ifdef RESULT_READER_SCORE_EN
    , .res_score_o(score)
`endif
  );

  mlp_result_reader #(.TIMEOUT_W(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .run_i(run_t), .busy_o(busy_t), .start_o(start_t),
    .done_intr_i(1'b0), .y_en_o(y_en_t), .y_addr_o(y_addr_t), .y_data_i(16'sd0),
    .res_valid_o(valid_t), .res_ready_i(1'b1), .res_class_o(cls_t), .res_pic_o(pic_t),
    .err_timeout_o(err_t), .all_done_o(all_done_t)
`ifdef RESULT_READER_SCORE_EN
    , .res_score_o(score_t)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) y_data <= mem[y_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic push_run;
    for (int p = 0; p < 10; p++) begin
      int best;
      logic signed [15:0] m;
      best = 0;
      m = mem[p*10];
      for (int k = 0; k < 10; k++) begin
        aq.push_back(p * 10 + k);
        if (k > 0 && mem[p*10+k] > m) begin
          m = mem[p*10+k];
          best = k;
        end
      end
      rq.push_back({4'(p), 4'(best)});
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (y_en) begin
      chk("addr_expected", 32'(aq.size() != 0), 1);
      if (aq.size() != 0) chk("y_addr", 32'(y_addr), aq.pop_front());
    end else chk("y_addr_idle", 32'(y_addr), 0);
    if (valid && ready) begin
      chk("res_expected", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) begin
        e_res = rq.pop_front();
        chk("res_pic", 32'(pic), 32'(e_res[7:4]));
        chk("res_class", 32'(cls), 32'(e_res[3:0]));
        n_res++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(int'($urandom_range(0, 15)) - 8);
    for (int k = 0; k < 10; k++) begin
      mem[k] = 16'(v0[k]);
      mem[10+k] = 16'(v1[k]);
    end
    neg;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_y_en", 32'(y_en), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_all_done", 32'(all_done), 0);
    chk("rst_busy_t", 32'(busy_t), 0);
    drv; rst_n = 1'b1;
    drv; run = 1'b1;
    drv; run = 1'b0;
    neg;
    chk("start_pulse", 32'(start), 1);
    chk("start_busy", 32'(busy), 1);
    neg;
    chk("start_once", 32'(start), 0);
    chk("wait_busy", 32'(busy), 1);
    drv; run = 1'b1;
    drv; run = 1'b0;
    neg;
    chk("run_ignored", 32'(start), 0);
    drv; done = 1'b1; push_run;
    neg;
    chk("y_en_cycle_T", 32'(y_en), 0);
    for (int i = 0; i < 10; i++) begin
      neg;
      chk("y_en_read", 32'(y_en), 1);
      chk("y_addr_k", 32'(y_addr), 32'(i));
    end
    neg;
    chk("valid_T11", 32'(valid), 0);
    chk("y_en_T11", 32'(y_en), 0);
    neg;
    chk("valid_T12", 32'(valid), 1);
    chk("class_pic0", 32'(cls), 2);
    chk("pic_pic0", 32'(pic), 0);
    repeat (5) begin
      neg;
      chk("hold0_valid", 32'(valid), 1);
      chk("hold0_class", 32'(cls), 2);
      chk("hold0_y_en", 32'(y_en), 0);
    end
    drv; ready = 1'b1;
    drv; ready = 1'b0;
    for (int i = 0; i < 40 && !valid; i++) neg;
    chk("pic1_valid", 32'(valid), 1);
    chk("class_neg", 32'(cls), 1);
    chk("pic_pic1", 32'(pic), 1);
    repeat (5) begin
      neg;
      chk("hold1_valid", 32'(valid), 1);
      chk("hold1_class", 32'(cls), 1);
      chk("hold1_pic", 32'(pic), 1);
      chk("hold1_y_en", 32'(y_en), 0);
    end
    drv; ready = 1'b1;
    for (int i = 0; i < 400 && !all_done; i++) neg;
    chk("all_done_seen", 32'(all_done), 1);
    chk("fin_busy", 32'(busy), 1);
    neg;
    chk("all_done_pulse", 32'(all_done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("results_run1", 32'(n_res), 10);
    chk("addr_q_empty", 32'(aq.size()), 0);
    chk("res_q_empty", 32'(rq.size()), 0);
    drv; run_t = 1'b1;
    drv; run_t = 1'b0;
    neg;
    chk("t_start", 32'(start_t), 1);
    repeat (15) begin
      neg;
      chk("t_wait_busy", 32'(busy_t), 1);
      chk("t_wait_err", 32'(err_t), 0);
    end
    neg;
    chk("t_tout_err", 32'(err_t), 1);
    chk("t_tout_busy", 32'(busy_t), 1);
    neg;
    chk("t_idle_busy", 32'(busy_t), 0);
    chk("t_idle_err", 32'(err_t), 1);
    repeat (3) neg;
    chk("t_err_held", 32'(err_t), 1);
    drv; run_t = 1'b1;
    drv; run_t = 1'b0;
    neg;
    chk("t_restart", 32'(start_t), 1);
    chk("t_err_clr", 32'(err_t), 0);
    drv; run = 1'b1;
    drv; run = 1'b0;
    repeat (20) begin
      neg;
      chk("level_no_read", 32'(y_en), 0);
    end
    drv; done = 1'b0;
    drv; done = 1'b1; push_run;
    for (int i = 0; i < 200 && !(y_en && y_addr == 10'd33); i++) neg;
    chk("reach_pic3", 32'(y_addr), 33);
    drv; rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_y_en", 32'(y_en), 0);
    chk("arst_y_addr", 32'(y_addr), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_class", 32'(cls), 0);
    chk("arst_pic", 32'(pic), 0);
    chk("arst_all_done", 32'(all_done), 0);
    aq.delete();
    rq.delete();
    drv; drv; rst_n = 1'b1;
    drv; run = 1'b1;
    drv; run = 1'b0;
    repeat (20) begin
      neg;
      chk("post_rst_no_read", 32'(y_en), 0);
    end
    drv; done = 1'b0;
    drv; done = 1'b1; push_run;
    for (int i = 0; i < 400 && !all_done; i++) neg;
    chk("all_done_run3", 32'(all_done), 1);
    neg;
    chk("idle_busy_run3", 32'(busy), 0);
    chk("addr_q_empty3", 32'(aq.size()), 0);
    chk("res_q_empty3", 32'(rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mlp_result_reader.md
MLP_RESULT_READER -- requirements
Module: mlp_result_reader

Interface
REQ-001 Parameters (name, default, meaning): MAX_NUMBER_PIC, 10, pictures per run; NUM_CLASS, 10, output neurons per picture; DATA_W, 16, y-buffer word width, signed two's complement; Y_BASE, 0, y-buffer address of picture 0 class 0; TIMEOUT_W, 20, watchdog counter width.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- run_i  in  1  host request for one inference run; level, sampled in IDLE only.
- busy_o  out  1  high in every state except IDLE.
- start_o  out  1  one-cycle start pulse to global controller start_i.
- done_intr_i  in  1  controller done level (stays high once set).
- y_en_o  out  1  y-buffer read enable.
- y_addr_o  out  10  y-buffer read address.
- y_data_i  in  DATA_W  y-buffer read data, valid 1 cycle after y_en_o.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accept.
- res_class_o  out  4  argmax class index.
- res_pic_o  out  4  picture index of result.
- err_timeout_o  out  1  sticky watchdog error.
- all_done_o  out  1  one-cycle pulse after last result accepted.

Function
REQ-003 FSM states SHALL be IDLE, START, WAIT, READ, EMIT, FIN, TOUT.
REQ-004 IDLE -> START when run_i=1; START lasts exactly one cycle with start_o=1, then WAIT.
REQ-005 WAIT SHALL detect a rising edge of done_intr_i (registered previous value 0, current 1); a level already high on WAIT entry SHALL NOT count.
REQ-006 Rising edge sampled at cycle T -> READ from T+1; pic counter=0.
REQ-007 READ: y_en_o=1 for NUM_CLASS consecutive cycles, y_addr_o = Y_BASE + pic*NUM_CLASS + k, k=0..NUM_CLASS-1, 10-bit truncation.
REQ-008 Data for k compared 1 cycle after its read; k=0 loads max unconditionally; later k replace max only if signed y_data_i > max (ties keep lowest index).
REQ-009 First res_valid_o SHALL assert at T+NUM_CLASS+2; res_class_o/res_pic_o stable while res_valid_o=1 and res_ready_i=0.
REQ-010 EMIT: transfer on res_valid_o&res_ready_i; then pic+1 -> READ next cycle, or after pic MAX_NUMBER_PIC-1 -> FIN.
REQ-011 FIN: all_done_o=1 for one cycle, -> IDLE.
REQ-012 WAIT watchdog counts every cycle from 0; on reaching 2^TIMEOUT_W-1 -> TOUT; err_timeout_o=1, held until next run_i accepted; TOUT -> IDLE after one cycle.
REQ-013 run_i SHALL be ignored outside IDLE; err_timeout_o SHALL clear in the START cycle.
REQ-014 y_en_o=0 and y_addr_o=0 outside READ.

Reset
REQ-015 rst_n low SHALL immediately force IDLE, all outputs 0, counters, max register and done_intr_i edge register 0, including mid-READ or mid-EMIT; an un-accepted result SHALL be discarded.
REQ-016 First run_i SHALL be sampled no earlier than the first rising clk after rst_n deasserts.

Configuration
REQ-017 Macro RESULT_READER_SCORE_EN: when defined, adds output res_score_o (DATA_W) carrying the winning signed score, stable with res_class_o, reset 0; when undefined, port and score output logic absent, all other behaviour identical.

Verification
REQ-018 run_i=1 one cycle -> start_o=1 exactly one cycle at next cycle, busy_o=1 until FIN.
REQ-019 done_intr_i rises at T with pic0 data {3,-1,7,7,0,...} -> y_addr_o 0..9 at T+1..T+10, res_valid_o at T+12, res_class_o=2, res_pic_o=0.
REQ-020 All scores negative {-5,-2,-9,...} -> class 1; res_ready_i held 0 for 5 cycles -> outputs stable, no read issued.
REQ-021 Full run, 10 pictures, res_ready_i=1 -> 10 results pic 0..9, addresses up to 99, all_done_o one pulse, busy_o=0 next cycle.
REQ-022 TIMEOUT_W=4, done_intr_i never rises -> TOUT after 15 WAIT cycles, err_timeout_o=1 until next run_i.
REQ-023 rst_n low during READ of pic 3 -> outputs 0 asynchronously; done_intr_i already high after reset -> no read until a new rising edge.
